// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the instruction-cycle sequencer: state codes,
// default HALT opcode and opcode class encodings.
package cpu_ctrl_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_LATCH  = 3'd2;
   localparam logic [2:0] ST_DECODE = 3'd3;
   localparam logic [2:0] ST_EXEC   = 3'd4;
   localparam logic [2:0] ST_HALT   = 3'd5;
   localparam logic [2:0] ST_FAULT  = 3'd6;

   localparam logic [3:0] HALT_OP_DEF = 4'hF;

   localparam logic CLS_ALU   = 1'b0;
   localparam logic CLS_STORE = 1'b1;

endpackage

// File: rtl/cycle_ctrl_timer.sv
// Fetch wait counter: counts FETCH cycles without mem_ready and flags the
// cycle on which the next miss would exhaust the TIMEOUT budget.
module cycle_ctrl_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic inc_i,
   output logic hit_o
);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   // clear has priority over increment
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = 8'd0;
      end else if (inc_i) begin
         cnt_d = cnt_q + 8'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign hit_o = (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_cycle_ctrl.sv
// Instruction-cycle sequencer producing register load-enable strobes.
// Define CYCLE_CTRL_STEP_EN to add a single-step input (one instruction per step edge).
module cpu_cycle_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int             OPW     = 4,
   parameter logic [OPW-1:0] HALT_OP = HALT_OP_DEF,
   parameter int             TIMEOUT = 15,
   parameter int             CNTW    = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            run,
`ifdef CYCLE_CTRL_STEP_EN
   input  logic            step,
`endif
   input  logic            mem_ready,
   input  logic [OPW-1:0]  opcode,
   output logic            mem_rd,
   output logic            ir_en,
   output logic            pc_en,
   output logic            acc_en,
   output logic            rf_we,
   output logic            halted,
   output logic            fault,
   output logic [CNTW-1:0] instr_cnt,
   output logic [2:0]      state_o
);

   logic [2:0]      state_q, state_d;
   logic            cls_q, cls_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            tmr_clr, tmr_inc, tmr_hit;
   logic            start_ok;
   logic            exec_loop;

`ifdef CYCLE_CTRL_STEP_EN
   logic step_q, step_qq;

   // two-stage step sampling; a start needs a registered rising edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step_q  <= 1'b0;
         step_qq <= 1'b0;
      end else begin
         step_q  <= step;
         step_qq <= step_q;
      end
   end

   assign start_ok  = run & step_q & ~step_qq;
   assign exec_loop = 1'b0;
`else
   assign start_ok  = run;
   assign exec_loop = run;
`endif

   cycle_ctrl_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .clr_i (tmr_clr),
      .inc_i (tmr_inc),
      .hit_o (tmr_hit)
   );

   // next-state logic; HALT and FAULT are terminal until reset
   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      tmr_clr = 1'b0;
      tmr_inc = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH: begin
            // a ready on the final budgeted cycle still wins over the timeout
            if (mem_ready) begin
               state_d = ST_LATCH;
               tmr_clr = 1'b1;
            end else begin
               tmr_inc = 1'b1;
               if (tmr_hit) begin
                  state_d = ST_FAULT;
               end else begin
                  state_d = ST_FETCH;
               end
            end
         end
         ST_LATCH: state_d = ST_DECODE;
         ST_DECODE: begin
            if (opcode == HALT_OP) begin
               state_d = ST_HALT;
            end else begin
               cls_d   = opcode[OPW-1] ? CLS_STORE : CLS_ALU;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (exec_loop) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HALT:  state_d = ST_HALT;
         ST_FAULT: state_d = ST_FAULT;
         default:  state_d = ST_IDLE;
      endcase
   end

   // retired-instruction counter, saturating
   always_comb begin
      cnt_d = cnt_q;
      if ((state_q == ST_EXEC) && (cnt_q != {CNTW{1'b1}})) begin
         cnt_d = cnt_q + CNTW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // state, opcode class and counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cls_q   <= CLS_ALU;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         cnt_q   <= cnt_d;
      end
   end

   assign mem_rd    = (state_q == ST_FETCH);
   assign ir_en     = (state_q == ST_LATCH);
   assign pc_en     = (state_q == ST_EXEC);
   assign acc_en    = (state_q == ST_EXEC) && (cls_q == CLS_ALU);
   assign rf_we     = (state_q == ST_EXEC) && (cls_q == CLS_STORE);
   assign halted    = (state_q == ST_HALT);
   assign fault     = (state_q == ST_FAULT);
   assign instr_cnt = cnt_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_cpu_cycle_ctrl.sv
// Scoreboard bench for cpu_cycle_ctrl: stimulus queues expected strobes,
// a negedge monitor pops and compares them; status is checked directly.
module tb_cpu_cycle_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic        mem_ready;
   logic [3:0]  opcode;
   logic        mem_rd, ir_en, pc_en, acc_en, rf_we, halted, fault;
   logic [15:0] instr_cnt;
   logic [2:0]  state_o;
`ifdef CYCLE_CTRL_STEP_EN
   logic        step;
`endif

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   typedef struct packed {
      logic [22:0] v;
      logic [31:0] c;
   } exp_t;

   exp_t exp_q[$];

   cpu_cycle_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .run       (run),
`ifdef CYCLE_CTRL_STEP_EN
      .step      (step),
`endif
      .mem_ready (mem_ready),
      .opcode    (opcode),
      .mem_rd    (mem_rd),
      .ir_en     (ir_en),
      .pc_en     (pc_en),
      .acc_en    (acc_en),
      .rf_we     (rf_we),
      .halted    (halted),
      .fault     (fault),
      .instr_cnt (instr_cnt),
      .state_o   (state_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input logic ir, input logic pc, input logic acc, input logic rf,
                           input logic [2:0] st, input int cnt, input int c);
      exp_t e;
      e.v = {ir, pc, acc, rf, st, cnt[15:0]};
      e.c = c;
      exp_q.push_back(e);
   endtask

   // monitor: every strobe cycle must match the next queued expectation
   always @(negedge clk) begin
      if (reset === 1'b0 && (ir_en | pc_en | acc_en | rf_we)) begin
         exp_t e;
         int   n;
         n = int'(ir_en) + int'(pc_en) + int'(acc_en) + int'(rf_we);
         vectors++;
         if (n > 2 || (n == 2 && !(pc_en && (acc_en ^ rf_we))) || (n == 1 && !ir_en)) begin
            miscompares++;
            $display("FAIL strobe_mix: ir/pc/acc/rf=%b%b%b%b at cycle %0d", ir_en, pc_en, acc_en, rf_we, cyc);
         end
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_strobe: ir/pc/acc/rf=%b%b%b%b state=%0d at cycle %0d, none expected",
                     ir_en, pc_en, acc_en, rf_we, state_o, cyc);
         end else begin
            e = exp_q.pop_front();
            if ({ir_en, pc_en, acc_en, rf_we, state_o, instr_cnt} !== e.v || cyc != int'(e.c)) begin
               miscompares++;
               $display("FAIL strobe: got {ir,pc,acc,rf,st,cnt}=%h at cycle %0d, expected %h at cycle %0d",
                        {ir_en, pc_en, acc_en, rf_we, state_o, instr_cnt}, cyc, e.v, e.c);
            end
         end
      end
   end

   task automatic do_reset();
      reset     = 1'b1;
      run       = 1'b0;
      mem_ready = 1'b0;
      opcode    = 4'h0;
`ifdef CYCLE_CTRL_STEP_EN
      step      = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // run n instructions back to back starting from IDLE
   task automatic run_instrs(input int n, input logic [3:0] op, input int base);
      int k;
      k         = cyc;
      opcode    = op;
      mem_ready = 1'b1;
      run       = 1'b1;
      for (int i = 0; i < n; i++) begin
         push_exp(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, base + i, k + 2 + 4 * i);
         push_exp(1'b0, 1'b1, ~op[3], op[3], 3'd4, base + i, k + 4 + 4 * i);
      end
      repeat (4 * (n - 1) + 1) @(posedge clk);
      #1 run = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("idle_after_run", 32'(state_o), 32'd0);
      check("instr_cnt", 32'(instr_cnt), 32'(base + n));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      do_reset();
      check("reset_outputs", {25'd0, mem_rd, ir_en, pc_en, acc_en, rf_we, halted, fault}, 32'd0);
      check("reset_state", 32'(state_o), 32'd0);
      check("reset_cnt", 32'(instr_cnt), 32'd0);

`ifdef CYCLE_CTRL_STEP_EN
      run = 1'b1; mem_ready = 1'b1; opcode = 4'h3;
      repeat (3) @(posedge clk);
      #1 check("step_wait_idle", 32'(state_o), 32'd0);
      for (int p = 0; p < 3; p++) begin
         k = cyc;
         push_exp(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, p, k + 3);
         push_exp(1'b0, 1'b1, 1'b1, 1'b0, 3'd4, p, k + 5);
         step = 1'b1;
         @(posedge clk);
         #1 step = 1'b0;
         repeat (6) @(posedge clk);
         #1;
         check("step_idle", 32'(state_o), 32'd0);
         check("step_cnt", 32'(instr_cnt), 32'(p + 1));
      end
`else
      // ALU instructions, then one STORE
      run_instrs(3, 4'h3, 0);
      run_instrs(1, 4'h9, 3);

      // fetch timeout
      do_reset();
      k = cyc; run = 1'b1; mem_ready = 1'b0; opcode = 4'h3;
      repeat (15) @(posedge clk);
      #1;
      check("to_still_fetch", 32'(state_o), 32'd1);
      check("to_mem_rd", 32'(mem_rd), 32'd1);
      check("to_no_fault_yet", 32'(fault), 32'd0);
      @(posedge clk);
      #1;
      check("to_fault_state", 32'(state_o), 32'd6);
      check("to_fault", 32'(fault), 32'd1);
      check("to_mem_rd_off", 32'(mem_rd), 32'd0);
      run = 1'b0; mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 run = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("fault_sticky", {29'd0, state_o}, 32'd6);
      check("fault_sticky_flag", 32'(fault), 32'd1);

      // ready on the last budgeted cycle wins
      do_reset();
      k = cyc; run = 1'b1; mem_ready = 1'b0; opcode = 4'h3;
      push_exp(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 0, k + 16);
      push_exp(1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 0, k + 18);
      repeat (15) @(posedge clk);
      #1;
      check("edge_fetch", 32'(state_o), 32'd1);
      mem_ready = 1'b1; run = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("edge_idle", 32'(state_o), 32'd0);
      check("edge_no_fault", 32'(fault), 32'd0);
      check("edge_cnt", 32'(instr_cnt), 32'd1);

      // HALT opcode
      do_reset();
      k = cyc; run = 1'b1; mem_ready = 1'b1; opcode = 4'hF;
      push_exp(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 0, k + 2);
      repeat (4) @(posedge clk);
      #1;
      check("halt_state", 32'(state_o), 32'd5);
      check("halted", 32'(halted), 32'd1);
      for (int i = 0; i < 8; i++) begin
         run = ~run;
         @(posedge clk);
         #1;
      end
      check("halt_sticky", 32'(state_o), 32'd5);
      check("halt_cnt", 32'(instr_cnt), 32'd0);
      check("halt_mem_rd", 32'(mem_rd), 32'd0);

      // asynchronous reset in the middle of EXEC
      do_reset();
      k = cyc; run = 1'b1; mem_ready = 1'b1; opcode = 4'h3;
      push_exp(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 0, k + 2);
      push_exp(1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 0, k + 4);
      push_exp(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1, k + 6);
      repeat (8) @(posedge clk);
      #1;
      check("pre_reset_exec", 32'(state_o), 32'd4);
      check("pre_reset_cnt", 32'(instr_cnt), 32'd1);
      #2 reset = 1'b1; run = 1'b0;
      #1;
      check("async_outputs", {25'd0, mem_rd, ir_en, pc_en, acc_en, rf_we, halted, fault}, 32'd0);
      check("async_state", 32'(state_o), 32'd0);
      check("async_cnt", 32'(instr_cnt), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      run_instrs(1, 4'h3, 0);
`endif

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
